// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the fetch/data memory arbiter
package mem_arb_pkg;

    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        RESP_NONE  = 2'd0,
        RESP_IF_RD = 2'd1,
        RESP_D_RD  = 2'd2
    } resp_owner_t;

    // Counter must hold STARVE_LIMIT itself; never narrower than 2 bits.
    function automatic int starve_cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// rtl/arb_starve_ctr.sv - saturating count of consecutive denied fetch cycles
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT,
    parameter int CNT_W = starve_cnt_width(LIMIT)
) (
    input  logic clock,
    input  logic clear,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT_V)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_limit = (r_cnt == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port RAM between fetch and MEM-stage data ports
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_stall,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wren,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    logic        w_force_if;
    logic        w_if_gnt;
    logic        w_d_gnt;
    resp_owner_t r_resp_owner;
    resp_owner_t w_resp_next;

    // Data wins by default; fetch wins only once it has been starved to the limit.
    always_comb begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        if (clear) begin
            if (d_req && !(if_req && w_force_if)) begin
                w_d_gnt = 1'b1;
            end else if (if_req) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clock      (clock),
        .clear      (clear),
        .i_clr      (w_if_gnt | ~if_req),
        .i_inc      (if_req & ~w_if_gnt),
        .o_at_limit (w_force_if)
    );

    always_comb begin
        w_resp_next = RESP_NONE;
        if (w_if_gnt) begin
            w_resp_next = RESP_IF_RD;
        end else if (w_d_gnt && !d_we) begin
            w_resp_next = RESP_D_RD;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_resp_owner <= RESP_NONE;
        end else begin
            r_resp_owner <= w_resp_next;
        end
    end

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign if_stall  = if_req & ~w_if_gnt;
    assign ram_addr  = w_d_gnt ? d_addr : if_addr;
    assign ram_wren  = w_d_gnt & d_we;
    assign ram_din   = d_wdata;
    assign if_rvalid = (r_resp_owner == RESP_IF_RD);
    assign d_rvalid  = (r_resp_owner == RESP_D_RD);
    assign if_rdata  = ram_dout;
    assign d_rdata   = ram_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural single-port RAM
module tb_mem_arbiter;

    logic        clock;
    logic        clear;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    int errors = 0;
    int checks = 0;
    logic [31:0] if_q[$];
    logic [31:0] d_q[$];
    logic [31:0] mem [256];
    logic [31:0] fetch_words [3];

    mem_arbiter dut (
        .clock     (clock),
        .clear     (clear),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .ram_addr  (ram_addr),
        .ram_wren  (ram_wren),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Read-first single-port RAM with a registered output.
    always @(posedge clock) begin
        if (ram_wren) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    always @(negedge clock) begin
        if (if_rvalid) begin
            checks++;
            if (if_q.size() == 0) begin
                errors++; $display("FAIL if_resp: unexpected if_rvalid rdata=%h", if_rdata);
            end else begin
                logic [31:0] e;
                e = if_q.pop_front();
                if (if_rdata !== e) begin errors++; $display("FAIL if_rdata: got %h want %h", if_rdata, e); end
            end
        end
        if (d_rvalid) begin
            checks++;
            if (d_q.size() == 0) begin
                errors++; $display("FAIL d_resp: unexpected d_rvalid rdata=%h", d_rdata);
            end else begin
                logic [31:0] e;
                e = d_q.pop_front();
                if (d_rdata !== e) begin errors++; $display("FAIL d_rdata: got %h want %h", d_rdata, e); end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drained(input string name);
        checks++;
        if (if_q.size() != 0 || d_q.size() != 0) begin
            errors++; $display("FAIL %s_drain: pending if=%0d d=%0d want 0 0", name, if_q.size(), d_q.size());
        end
        if_q.delete(); d_q.delete();
    endtask

    task automatic test_reset();
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 8'h00; d_addr = 8'h10;
        #2;
        checks++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got if=%b d=%b want 0 0", if_gnt, d_gnt); end
        checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got if=%b d=%b want 0 0", if_rvalid, d_rvalid); end
        checks++; if (dut.u_starve.r_cnt !== '0) begin errors++; $display("FAIL reset_starve: got %0d want 0", dut.u_starve.r_cnt); end
        @(negedge clock);
        if_req = 1'b0; d_req = 1'b0;
        clear = 1'b1;
        cyc();
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i < 3) begin
                if_req = 1'b1; if_addr = 8'(i);
                if_q.push_back(fetch_words[i]);
            end else begin
                if_req = 1'b0;
            end
            #4;
            if (i < 3) begin
                checks++; if (if_gnt !== 1'b1 || if_stall !== 1'b0) begin errors++; $display("FAIL fetch_gnt[%0d]: got gnt=%b stall=%b want 1 0", i, if_gnt, if_stall); end
            end
            checks++; if (if_rvalid !== (i > 0)) begin errors++; $display("FAIL fetch_rvalid[%0d]: got %b want %b", i, if_rvalid, (i > 0)); end
        end
        cyc(); #4;
        drained("fetch");
    endtask

    task automatic test_conflict();
        cyc();
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10; if_req = 1'b1; if_addr = 8'h03;
        d_q.push_back(32'hDEADBEEF);
        #4;
        checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || if_stall !== 1'b1) begin errors++; $display("FAIL conflict_gnt: got d=%b if=%b stall=%b want 1 0 1", d_gnt, if_gnt, if_stall); end
        checks++; if (ram_addr !== 8'h10) begin errors++; $display("FAIL conflict_addr: got %h want 10", ram_addr); end
        cyc();
        d_req = 1'b0; if_req = 1'b0;
        #4;
        checks++; if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin errors++; $display("FAIL conflict_rvalid: got d=%b if=%b want 1 0", d_rvalid, if_rvalid); end
        cyc(); #4;
        drained("conflict");
    endtask

    task automatic test_starve();
        logic want_if;
        for (int i = 0; i < 6; i++) begin
            cyc();
            d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10; if_req = 1'b1; if_addr = 8'h01;
            want_if = (i == 4);
            if (want_if) if_q.push_back(fetch_words[1]);
            else         d_q.push_back(32'hDEADBEEF);
            #4;
            checks++; if (if_gnt !== want_if || d_gnt !== !want_if) begin errors++; $display("FAIL starve_gnt[%0d]: got if=%b d=%b want %b %b", i, if_gnt, d_gnt, want_if, !want_if); end
            if (i == 5) begin
                checks++; if (dut.u_starve.r_cnt !== '0) begin errors++; $display("FAIL starve_cnt_back: got %0d want 0", dut.u_starve.r_cnt); end
            end
        end
        cyc();
        d_req = 1'b0; if_req = 1'b0;
        cyc(); #4;
        drained("starve");
    endtask

    task automatic test_write_read();
        cyc();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h05; d_wdata = 32'h0000_00AA;
        #4;
        checks++; if (ram_wren !== 1'b1 || d_gnt !== 1'b1 || ram_addr !== 8'h05 || ram_din !== 32'h0000_00AA) begin errors++; $display("FAIL wr_drive: got wren=%b gnt=%b addr=%h din=%h want 1 1 05 000000aa", ram_wren, d_gnt, ram_addr, ram_din); end
        cyc();
        d_we = 1'b0; d_wdata = 32'h1234_5678;
        d_q.push_back(32'h0000_00AA);
        #4;
        checks++; if (ram_wren !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rd_after_wr: got wren=%b rvalid=%b want 0 0", ram_wren, d_rvalid); end
        cyc();
        d_req = 1'b0;
        #4;
        checks++; if (d_rvalid !== 1'b1) begin errors++; $display("FAIL raw_rvalid: got %b want 1", d_rvalid); end
        cyc(); #4;
        drained("raw");
    endtask

    task automatic test_reset_mid();
        cyc();
        if_req = 1'b1; if_addr = 8'h02;
        #4;
        checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: got %b want 1", if_gnt); end
        #3;
        clear = 1'b0; if_req = 1'b0;
        cyc();
        checks++; if (if_rvalid !== 1'b0 || dut.u_starve.r_cnt !== '0) begin errors++; $display("FAIL rstmid_state: got rvalid=%b cnt=%0d want 0 0", if_rvalid, dut.u_starve.r_cnt); end
        #5;
        clear = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(); #4;
            checks++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_post[%0d]: got if=%b d=%b want 0 0", i, if_rvalid, d_rvalid); end
        end
        drained("rstmid");
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            cyc();
            if_req = 1'b0; d_req = 1'b0; d_we = 1'b1; if_addr = 8'h2A; d_addr = 8'h55;
            #4;
            checks++; if (if_gnt !== 1'b0 || d_gnt !== 1'b0 || ram_wren !== 1'b0 || if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL idle[%0d]: got ig=%b dg=%b wren=%b irv=%b drv=%b want all 0", i, if_gnt, d_gnt, ram_wren, if_rvalid, d_rvalid); end
            checks++; if (ram_addr !== 8'h2A || dut.u_starve.r_cnt !== '0) begin errors++; $display("FAIL idle_addr_cnt[%0d]: got addr=%h cnt=%0d want 2a 0", i, ram_addr, dut.u_starve.r_cnt); end
        end
        d_we = 1'b0;
        drained("idle");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        fetch_words[0] = 32'h00100093;
        fetch_words[1] = 32'h00200113;
        fetch_words[2] = 32'h00209463;
        for (int i = 0; i < 3; i++) mem[i] = fetch_words[i];
        mem[8'h10] = 32'hDEADBEEF;
        clear = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        test_reset();
        test_fetch();
        test_conflict();
        test_starve();
        test_write_read();
        test_reset_mid();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
